// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: drives a simple req/ack bus, stalls the pipeline
// while a transaction is outstanding, and formats load data into readdata_m.
// Optional feature: define MISALIGN_EXC_EN to flag misaligned half/word accesses
// instead of issuing them.
module memory_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_m,
  input  logic        memwrite_m,
  input  logic [1:0]  size_m,
  input  logic        unsigned_m,
  input  logic [31:0] aluout_m,
  input  logic [31:0] writedata_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] readdata_m,
  output logic        stall_m,
  output logic        exc_misalign_m
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        access;
  logic        misaligned;
  logic        start;
  logic        load_capture;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign access = memread_m | memwrite_m;

`ifdef MISALIGN_EXC_EN
  // Half needs addr[0]=0; word (size 10 or 11) needs addr[1:0]=00.
  assign misaligned = ((size_m == 2'b01) && aluout_m[0]) ||
                      (size_m[1] && (aluout_m[1:0] != 2'b00));
  assign exc_misalign_m = ~reset & (state_q == IDLE) & access & misaligned;
`else
  assign misaligned     = 1'b0;
  assign exc_misalign_m = 1'b0;
`endif

  // A new access is only recognised in IDLE; DONE ignores the still-present access.
  assign start   = (state_q == IDLE) & access & ~misaligned;
  assign mem_req = ~reset & (start | (state_q == WAIT));
  assign stall_m = mem_req;
  assign mem_we  = mem_req & memwrite_m;
  assign mem_addr = {aluout_m[31:2], 2'b00};

  // Store wins over load when both are asserted, so no capture then.
  assign load_capture = mem_req & mem_ack & memread_m & ~memwrite_m;

  // Next-state logic for the request FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = mem_ack ? DONE : WAIT;
      WAIT:    if (mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte-enable generation from size and address low bits.
  always_comb begin
    mem_be = 4'b0000;
    if (mem_req) begin
      unique case (size_m)
        2'b00:   mem_be = 4'b0001 << aluout_m[1:0];
        2'b01:   mem_be = aluout_m[1] ? 4'b1100 : 4'b0011;
        default: mem_be = 4'b1111;
      endcase
    end
  end

  // Store data replicated across lanes so the enabled lanes carry the right bytes.
  always_comb begin
    unique case (size_m)
      2'b00:   mem_wdata = {4{writedata_m[7:0]}};
      2'b01:   mem_wdata = {2{writedata_m[15:0]}};
      default: mem_wdata = writedata_m;
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    unique case (aluout_m[1:0])
      2'b00:   load_byte = mem_rdata[7:0];
      2'b01:   load_byte = mem_rdata[15:8];
      2'b10:   load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = aluout_m[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_m)
      2'b00:   load_data = {{24{~unsigned_m & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{~unsigned_m & load_half[15]}}, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Load result register; holds through stores, non-memory ops and stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             readdata_m <= 32'h0;
    else if (load_capture) readdata_m <= load_data;
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: directed accesses push expected bus
// fields and load results; a negedge monitor checks them as the DUT presents them.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread_m, memwrite_m, unsigned_m;
  logic [1:0]  size_m;
  logic [31:0] aluout_m, writedata_m;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, readdata_m;
  logic [3:0]  mem_be;
  logic        stall_m, exc_misalign_m;

  memory_access_unit dut (
    .clk(clk), .reset(reset), .memread_m(memread_m), .memwrite_m(memwrite_m),
    .size_m(size_m), .unsigned_m(unsigned_m), .aluout_m(aluout_m),
    .writedata_m(writedata_m), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .readdata_m(readdata_m), .stall_m(stall_m),
    .exc_misalign_m(exc_misalign_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          stalls;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          stall_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    memread_m = 1'b0; memwrite_m = 1'b0; size_m = 2'b10; unsigned_m = 1'b0;
    aluout_m = 32'h0; writedata_m = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  // One access: IDLE cycle, 'waits' further cycles with ack in the last, then DONE.
  task automatic run(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                     input int waits, input logic [3:0] be, input logic [31:0] wdata,
                     input logic [31:0] rd_exp);
    exp_t e;
    e.addr = {addr[31:2], 2'b00}; e.we = wr; e.be = be; e.wdata = wdata;
    e.rd = rd_exp; e.stalls = waits + 1;
    exp_q.push_back(e);
    memread_m = rd; memwrite_m = wr; size_m = sz; unsigned_m = uns;
    aluout_m = addr; writedata_m = wd; mem_rdata = rdata; mem_ack = (waits == 0);
    for (int k = 1; k <= waits; k++) begin
      @(posedge clk); #1;
      mem_ack = (k == waits);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;  // DONE: access still presented, must be ignored
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Monitor: checks bus fields while requesting, stall length and DONE-cycle result.
  always @(negedge clk) begin
    if (reset) begin
      stall_cnt = 0;
      pend = 1'b0;
    end else begin
      if (stall_m) stall_cnt++;
      if (pend) begin
        chk("done_readdata", readdata_m, pend_rd);
        chk("done_req", {31'b0, mem_req}, 32'h0);
        chk("done_stall", {31'b0, stall_m}, 32'h0);
        pend = 1'b0;
      end
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          chk("req_unexpected", {31'b0, mem_req}, 32'h0);
        end else begin
          mon_e = exp_q[0];
          chk("bus_addr", mem_addr, mon_e.addr);
          chk("bus_we", {31'b0, mem_we}, {31'b0, mon_e.we});
          chk("bus_be", {28'b0, mem_be}, {28'b0, mon_e.be});
          chk("bus_wdata", mem_wdata, mon_e.wdata);
          if (mem_ack) begin
            chk("stall_cycles", 32'(stall_cnt), 32'(mon_e.stalls));
            stall_cnt = 0;
            pend = 1'b1;
            pend_rd = mon_e.rd;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("idle_be", {28'b0, mem_be}, 32'h0);
        chk("idle_we", {31'b0, mem_we}, 32'h0);
      end
`ifndef MISALIGN_EXC_EN
      chk("exc_tied", {31'b0, exc_misalign_m}, 32'h0);
`endif
    end
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    memread_m = 1'b1;  // access present during reset must not request
    mem_ack = 1'b1;
    #1;
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_stall", {31'b0, stall_m}, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_readdata", readdata_m, 32'h0);
    chk("rst_exc", {31'b0, exc_misalign_m}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    chk("nonaccess_stall", {31'b0, stall_m}, 32'h0);
    chk("nonaccess_req", {31'b0, mem_req}, 32'h0);

    // rd wr  sz     uns  addr          wd            rdata         waits be       wdata         expected readdata
    run(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
    run(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 3, 4'b1000, 32'h0,        32'hFFFF_FF80);
    run(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 3, 4'b1000, 32'h0,        32'h0000_0080);
    run(0, 1, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080);
    run(1, 0, 2'b01, 0, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 4'b1100, 32'h0,        32'hFFFF_8001);
    run(1, 0, 2'b01, 1, 32'h0000_0000, 32'h0,        32'h8001_F00F, 2, 4'b0011, 32'h0,        32'h0000_F00F);
    run(1, 0, 2'b00, 0, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 4'b0010, 32'h0,        32'h0000_007F);
    run(0, 1, 2'b00, 0, 32'h0000_0002, 32'h0000_00A5, 32'h0,       1, 4'b0100, 32'hA5A5_A5A5, 32'h0000_007F);
    run(1, 1, 2'b10, 0, 32'h0000_0300, 32'hCAFE_F00D, 32'h1111_1111, 0, 4'b1111, 32'hCAFE_F00D, 32'h0000_007F);
    run(1, 0, 2'b10, 0, 32'h0000_0000, 32'h0,        32'h0102_0304, 0, 4'b1111, 32'h0,        32'h0102_0304);
    run(1, 0, 2'b10, 0, 32'h0000_0004, 32'h0,        32'hA0B0_C0D0, 0, 4'b1111, 32'h0,        32'hA0B0_C0D0);

    // Stray ack with no request is ignored.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    idle_inputs();
    chk("stray_ack_readdata", readdata_m, 32'hA0B0_C0D0);

    run(1, 0, 2'b11, 0, 32'h0000_0008, 32'h0,        32'h55AA_55AA, 1, 4'b1111, 32'h0,        32'h55AA_55AA);

`ifdef MISALIGN_EXC_EN
    memread_m = 1'b1; size_m = 2'b10; aluout_m = 32'h0000_0101; mem_rdata = 32'h1357_9BDF;
    #1;
    chk("misalign_exc", {31'b0, exc_misalign_m}, 32'h1);
    chk("misalign_req", {31'b0, mem_req}, 32'h0);
    chk("misalign_stall", {31'b0, stall_m}, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("misalign_exc_clear", {31'b0, exc_misalign_m}, 32'h0);
    chk("misalign_readdata", readdata_m, 32'h55AA_55AA);
`else
    run(1, 0, 2'b10, 0, 32'h0000_0101, 32'h0,        32'h1357_9BDF, 0, 4'b1111, 32'h0,        32'h1357_9BDF);
    run(1, 0, 2'b01, 1, 32'h0000_0003, 32'h0,        32'hBEEF_0000, 0, 4'b1100, 32'h0,        32'h0000_BEEF);
`endif

    // Reset while in WAIT abandons the transaction; a late ack is ignored.
    begin
      exp_t e;
      e.addr = 32'h10; e.we = 1'b0; e.be = 4'b1111; e.wdata = 32'h0;
      e.rd = 32'h0; e.stalls = 0;
      exp_q.push_back(e);
    end
    memread_m = 1'b1; size_m = 2'b10; aluout_m = 32'h0000_0010; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("wait_stall", {31'b0, stall_m}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstwait_req", {31'b0, mem_req}, 32'h0);
    chk("rstwait_stall", {31'b0, stall_m}, 32'h0);
    chk("rstwait_be", {28'b0, mem_be}, 32'h0);
    chk("rstwait_readdata", readdata_m, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    memread_m = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    chk("late_ack_req", {31'b0, mem_req}, 32'h0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_readdata", readdata_m, 32'h0);
    chk("late_ack_stall", {31'b0, stall_m}, 32'h0);

    run(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0,        32'h0BAD_F00D, 2, 4'b1111, 32'h0,        32'h0BAD_F00D);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
